// File: rtl/r2sdf_twiddle_seq_pkg.sv
// Shared constants and size helpers for the R2SDF FFT stage blocks.
// Used by the twiddle sequencer and the coefficient ROM.
package r2sdf_pkg;

   // FFT size N for a ROM address width of aw bits (half-wave tables).
   function automatic int unsigned fft_size(input int unsigned aw);
      return 32'd1 << (aw + 32'd1);
   endfunction

   // Butterfly half-span L of a given stage.
   function automatic int unsigned half_span(input int unsigned aw, input int unsigned stage);
      return 32'd1 << (aw - stage);
   endfunction

   // Coefficient full-scale value 2^(dw-1)-1 for a signed Q1.(dw-1) word.
   function automatic longint full_scale(input int unsigned dw);
      return (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
   endfunction

endpackage

// File: rtl/r2sdf_twiddle_seq_coef_rom.sv
// Half-wave cosine or sine table with a registered read port.
// Contents are elaboration-time constants; nothing resets them.
module R2SdfCoefRom
   import r2sdf_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 8,
   parameter string       RI = "Real"
) (
   input  logic                 clk_i,
   input  logic [AW-1:0]        addr_i,
   output logic signed [DW-1:0] data_o
);

   localparam int unsigned DEPTH   = fft_size(AW) / 32'd2;
   localparam bit          IS_IMAG = (RI == "Imag");

   localparam longint PI_Q30   = 64'sd3373259426;
   localparam longint ONE_Q30  = 64'sd1 <<< 30;
   localparam longint HALF_Q30 = 64'sd1 <<< 29;

   // cos/sin of pi*k/2^AW in Q30, folded onto [0, pi/2] and summed as a Taylor series.
   function automatic longint trig_q30(input int unsigned k, input bit want_sin);
      int unsigned half;
      int unsigned kr;
      bit          neg;
      longint      x;
      longint      x2;
      longint      term;
      longint      acc;
      half = 32'd1 << (AW - 32'd1);
      kr   = k;
      neg  = 1'b0;
      if (k > half) begin
         kr  = (32'd1 << AW) - k;
         neg = !want_sin;
      end
      x  = (PI_Q30 * longint'(kr)) >>> AW;
      x2 = (x * x) >>> 30;
      if (want_sin) begin
         term = x;
         acc  = x;
         for (int unsigned i = 1; i <= 10; i++) begin
            term = -((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1));
            acc  = acc + term;
         end
      end else begin
         term = ONE_Q30;
         acc  = ONE_Q30;
         for (int unsigned i = 1; i <= 10; i++) begin
            term = -((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
            acc  = acc + term;
         end
      end
      if (acc < 0) begin
         acc = 0;
      end
      return neg ? -acc : acc;
   endfunction

   // Round-half-away-from-zero scaling to full-scale integer.
   function automatic longint to_coef(input longint q30);
      longint fs;
      fs = full_scale(DW);
      if (q30 < 0) begin
         return -((((-q30) * fs) + HALF_Q30) >>> 30);
      end
      return ((q30 * fs) + HALF_Q30) >>> 30;
   endfunction

   logic signed [DW-1:0] table_w [DEPTH];
   logic signed [DW-1:0] data_q;

   for (genvar k = 0; k < DEPTH; k++) begin : g_tab
      localparam longint VAL = to_coef(trig_q30(k, IS_IMAG));
      assign table_w[k] = DW'(VAL);
   end

   always_ff @(posedge clk_i) begin
      data_q <= table_w[addr_i];
   end

   assign data_o = data_q;

endmodule

// File: rtl/r2sdf_twiddle_seq.sv
// Per-stage twiddle sequencer: position counter, ROM addressing, and
// forward/inverse sign stage, three registers deep, one twiddle per sample.
module r2sdf_twiddle_seq
   import r2sdf_pkg::*;
#(
   parameter int unsigned DW    = 16,
   parameter int unsigned AW    = 8,
   parameter int unsigned STAGE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 sync,
   input  logic                 inv,
   output logic                 out_valid,
   output logic                 out_first,
   output logic signed [DW-1:0] coef_re,
   output logic signed [DW-1:0] coef_im
);

   localparam int unsigned L      = half_span(AW, STAGE);
   localparam logic [AW:0] L_C    = (AW + 1)'(L);
   localparam logic [AW:0] LAST_C = (AW + 1)'(2 * L - 1);

   logic [AW:0]          cnt_q, cnt_d;
   logic [AW:0]          pos;
   logic [AW:0]          off;
   logic [AW-1:0]        addr_d, addr_q;
   logic                 v1_q, f1_q, inv1_q;
   logic                 v2_q, f2_q, inv2_q;
   logic                 out_valid_q, out_first_q;
   logic signed [DW-1:0] coef_re_q, coef_im_q;
   logic signed [DW-1:0] coef_im_d;
   logic signed [DW-1:0] rom_re, rom_im;

   // A sync accompanying a sample forces that sample to position 0.
   always_comb begin
      pos   = sync ? '0 : cnt_q;
      cnt_d = cnt_q;
      if (in_valid) begin
         cnt_d = (pos == LAST_C) ? '0 : pos + 1'b1;
      end else if (sync) begin
         cnt_d = '0;
      end
   end

   always_comb begin
      off    = pos - L_C;
      addr_d = (pos >= L_C) ? AW'(off << STAGE) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         addr_q <= '0;
         v1_q   <= 1'b0;
         f1_q   <= 1'b0;
         inv1_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
         v1_q   <= in_valid;
         f1_q   <= in_valid && (pos == '0);
         inv1_q <= inv;
      end
   end

   R2SdfCoefRom #(
      .DW (DW),
      .AW (AW),
      .RI ("Real")
   ) u_rom_re (
      .clk_i  (clk),
      .addr_i (addr_q),
      .data_o (rom_re)
   );

   R2SdfCoefRom #(
      .DW (DW),
      .AW (AW),
      .RI ("Imag")
   ) u_rom_im (
      .clk_i  (clk),
      .addr_i (addr_q),
      .data_o (rom_im)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q   <= 1'b0;
         f2_q   <= 1'b0;
         inv2_q <= 1'b0;
      end else begin
         v2_q   <= v1_q;
         f2_q   <= f1_q;
         inv2_q <= inv1_q;
      end
   end

   // Table sine is never negative, so negating it cannot overflow.
   assign coef_im_d = inv2_q ? rom_im : -rom_im;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         coef_re_q   <= '0;
         coef_im_q   <= '0;
      end else begin
         out_valid_q <= v2_q;
         out_first_q <= v2_q && f2_q;
         if (v2_q) begin
            coef_re_q <= rom_re;
            coef_im_q <= coef_im_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_first = out_first_q;
   assign coef_re   = coef_re_q;
   assign coef_im   = coef_im_q;

endmodule
